pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller. It consumes the decoded control bundle latched by the ID-control stage (the instruction now in ID/EX) and the register fields of the instruction in IF/ID.
- It generates the stall/flush signals that drive the IF register, the ID-control register and the EX stage.
- It sequences load-use bubbles, multi-cycle MDU operations (start/done handshake with timeout) and control-flow redirect flushes.
- It keeps a saturating stall-cycle performance counter.

Parameters:
- MDU_TIMEOUT, 64, maximum cycles to wait for mdu_done before flagging an error and releasing the stall.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rs1_IF  in  5  rs1 field of the instruction in IF/ID (instruction_IF[19:15])
- rs2_IF  in  5  rs2 field of the instruction in IF/ID (instruction_IF[24:20])
- rs1_used_IF  in  1  instruction in IF/ID reads rs1
- rs2_used_IF  in  1  instruction in IF/ID reads rs2
- rd_EX  in  5  destination register of the instruction in ID/EX
- rf_wr_en_EX  in  1  instruction in ID/EX writes the register file
- dm_rd_ctrl_EX  in  3  load control of ID/EX; nonzero means load
- m_sel_EX  in  1  instruction in ID/EX is a mul/div
- redirect_EX  in  1  EX resolved a taken branch or jump this cycle
- mdu_done  in  1  MDU result valid (one-cycle pulse)
- mdu_start  out  1  one-cycle pulse launching the MDU
- stall_ifr  out  1  hold PC and IF/ID register
- flush_ifr  out  1  clear IF/ID register
- stall_idc  out  1  hold ID-control register
- flush_idc  out  1  clear ID-control register (bubble); overrides stall_idc in the consumer
- stall_ex  out  1  hold EX/MEM inputs while the MDU is busy
- mdu_err  out  1  sticky timeout flag
- stall_cycles  out  CNT_W  saturating count of cycles with stall_ifr=1

Behaviour:
Reset (async, active-high):
- State goes to IDLE.
- All outputs are 0, including stall_cycles and mdu_err. The timeout counter clears.
- A reset asserted mid-MDU or mid-bubble aborts immediately. No mdu_start is issued after reset deasserts until a new m_sel_EX arrives.

States: IDLE, MDU_START, MDU_WAIT.

Hazard term:
- load_use = (dm_rd_ctrl_EX!=0) & rf_wr_en_EX & (rd_EX!=0) & ((rs1_used_IF & rs1_IF==rd_EX) | (rs2_used_IF & rs2_IF==rd_EX)).

IDLE outputs are combinational, with priority highest first:
1. redirect_EX: flush_ifr=1, flush_idc=1, all stalls 0. A simultaneous load_use or m_sel_EX is ignored, because those instructions are either wrong-path or already in EX.
2. m_sel_EX: stall_ifr=stall_idc=stall_ex=1; next state MDU_START.
3. load_use: stall_ifr=1, flush_idc=1, stall_idc=0. This inserts exactly one bubble. The next cycle re-evaluates with the load in MEM, so the hazard clears naturally.
4. Otherwise all outputs are 0.

MDU_START:
- mdu_start=1 for exactly one cycle.
- stall_ifr=stall_idc=stall_ex=1.
- The timeout counter loads 0. Next state is MDU_WAIT.

MDU_WAIT:
- stall_ifr=stall_idc=stall_ex=1. The counter increments each cycle.
- On mdu_done: the same cycle still stalls; next state is IDLE with stalls released the following cycle. The mul/div instruction then advances and is not re-launched, because the consumer clears m_sel when the ID/EX register advances.
- On counter==MDU_TIMEOUT-1 without mdu_done: set mdu_err=1 (sticky until reset) and go to IDLE.
- mdu_done arriving in IDLE or MDU_START is ignored.
- redirect_EX is ignored while not IDLE, because EX is stalled.

Performance counter:
- stall_cycles increments on every cycle in which stall_ifr=1.
- It saturates at all-ones and does not wrap.

General:
- The flush and stall outputs are combinational from state and inputs; they have no register delay.

Test Plan:
- Load-use: ID/EX holds a load (dm_rd_ctrl_EX=3'b010, rd_EX=5, rf_wr_en_EX=1); IF/ID has rs1_IF=5, rs1_used_IF=1 -> stall_ifr=1 and flush_idc=1 for exactly 1 cycle. Same stimulus with rd_EX=0 -> no stall.
- MDU: m_sel_EX=1, with mdu_done pulsed 4 cycles after mdu_start -> mdu_start high for 1 cycle; stall_ex high for 6 cycles total; stall_cycles=6; mdu_err=0.
- Timeout: m_sel_EX=1 with mdu_done never asserted, MDU_TIMEOUT=8 -> mdu_err rises after MDU_START plus 8 wait cycles and stays 1; stalls drop the next cycle.
- Redirect with load-use in the same cycle -> flush_ifr=flush_idc=1 and stall_ifr=0; no extra bubble on the next cycle.
- Reset in MDU_WAIT -> all outputs 0 immediately (asynchronous). After release, a late mdu_done causes no state change and mdu_start stays 0.
- Saturation: with CNT_W=4, hold m_sel-induced stalls for more than 15 cycles -> stall_cycles stops at 4'hF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: IF/ID and ID/EX hazard fields plus MDU handshake in,
// stall/flush/MDU controls and status out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs1_IF;
    logic [4:0]       rs2_IF;
    logic             rs1_used_IF;
    logic             rs2_used_IF;
    logic [4:0]       rd_EX;
    logic             rf_wr_en_EX;
    logic [2:0]       dm_rd_ctrl_EX;
    logic             m_sel_EX;
    logic             redirect_EX;
    logic             mdu_done;
    logic             mdu_start;
    logic             stall_ifr;
    logic             flush_ifr;
    logic             stall_idc;
    logic             flush_idc;
    logic             stall_ex;
    logic             mdu_err;
    logic [CNT_W-1:0] stall_cycles;

    // Pipeline side: drives hazard fields and MDU completion, consumes controls.
    modport master (
        output rs1_IF, rs2_IF, rs1_used_IF, rs2_used_IF, rd_EX, rf_wr_en_EX,
               dm_rd_ctrl_EX, m_sel_EX, redirect_EX, mdu_done,
        input  mdu_start, stall_ifr, flush_ifr, stall_idc, flush_idc, stall_ex,
               mdu_err, stall_cycles
    );

    // Controller side.
    modport slave (
        input  rs1_IF, rs2_IF, rs1_used_IF, rs2_used_IF, rd_EX, rf_wr_en_EX,
               dm_rd_ctrl_EX, m_sel_EX, redirect_EX, mdu_done,
        output mdu_start, stall_ifr, flush_ifr, stall_idc, flush_idc, stall_ex,
               mdu_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: load-use bubbles, MDU start/done sequencing with
// timeout, redirect flushes and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned TMO_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MDU_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MDU_START = 2'd1,
        MDU_WAIT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    logic rs1_hit, rs2_hit, load_use;
    logic stall_ifr, flush_ifr, stall_idc, flush_idc, stall_ex;

    // Load in ID/EX whose destination is read by the instruction in IF/ID.
    assign rs1_hit  = bus.rs1_used_IF & (bus.rs1_IF == bus.rd_EX);
    assign rs2_hit  = bus.rs2_used_IF & (bus.rs2_IF == bus.rd_EX);
    assign load_use = (bus.dm_rd_ctrl_EX != 3'd0) & bus.rf_wr_en_EX &
                      (bus.rd_EX != 5'd0) & (rs1_hit | rs2_hit);

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        stall_ifr = 1'b0;
        flush_ifr = 1'b0;
        stall_idc = 1'b0;
        flush_idc = 1'b0;
        stall_ex  = 1'b0;

        case (state_q)
            IDLE: begin
                // Redirect wins: the younger hazards are wrong-path or already in EX.
                if (bus.redirect_EX) begin
                    flush_ifr = 1'b1;
                    flush_idc = 1'b1;
                end else if (bus.m_sel_EX) begin
                    stall_ifr = 1'b1;
                    stall_idc = 1'b1;
                    stall_ex  = 1'b1;
                    state_d   = MDU_START;
                end else if (load_use) begin
                    stall_ifr = 1'b1;
                    flush_idc = 1'b1;
                end
            end
            MDU_START: begin
                stall_ifr = 1'b1;
                stall_idc = 1'b1;
                stall_ex  = 1'b1;
                tmo_d     = '0;
                state_d   = MDU_WAIT;
            end
            MDU_WAIT: begin
                stall_ifr = 1'b1;
                stall_idc = 1'b1;
                stall_ex  = 1'b1;
                if (bus.mdu_done) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are forced quiet for as long as reset is held.
        if (reset) begin
            stall_ifr = 1'b0;
            flush_ifr = 1'b0;
            stall_idc = 1'b0;
            flush_idc = 1'b0;
            stall_ex  = 1'b0;
        end
    end

    assign start_d = (state_d == MDU_START);
    assign cyc_d   = (stall_ifr && (cyc_q != {CNT_W{1'b1}})) ? cyc_q + CNT_W'(1) : cyc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            start_q <= start_d;
            cyc_q   <= cyc_d;
        end
    end

    assign bus.mdu_start    = start_q;
    assign bus.stall_ifr    = stall_ifr;
    assign bus.flush_ifr    = flush_ifr;
    assign bus.stall_idc    = stall_idc;
    assign bus.flush_idc    = flush_idc;
    assign bus.stall_ex     = stall_ex;
    assign bus.mdu_err      = err_q;
    assign bus.stall_cycles = cyc_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: per-cycle expected output
// vectors are queued with the stimulus and popped at the following negedge.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MDU_TIMEOUT = 8;
    localparam int unsigned EXP_W       = CNT_W + 7;

    // {stall_ifr, flush_ifr, stall_idc, flush_idc, stall_ex}
    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_LU    = 5'b10010;
    localparam logic [4:0] C_FLUSH = 5'b01010;
    localparam logic [4:0] C_MDU   = 5'b10101;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic [4:0] rd;
        logic       wr;
        logic [2:0] dm;
        logic       msel;
        logic       redir;
        logic       done;
    } in_t;

    typedef struct {
        string            tag;
        logic [EXP_W-1:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    exp_t             sb[$];
    int               passed = 0;
    int               failed = 0;
    int               total  = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             exp_err = 1'b0;

    in_t z, lu, lb, m, d, t, rz;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .MDU_TIMEOUT(MDU_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic apply(input in_t i);
        bus.rs1_IF        = i.rs1;
        bus.rs2_IF        = i.rs2;
        bus.rs1_used_IF   = i.rs1_used;
        bus.rs2_used_IF   = i.rs2_used;
        bus.rd_EX         = i.rd;
        bus.rf_wr_en_EX   = i.wr;
        bus.dm_rd_ctrl_EX = i.dm;
        bus.m_sel_EX      = i.msel;
        bus.redirect_EX   = i.redir;
        bus.mdu_done      = i.done;
    endtask

    // Queue the expected vector; the stall counter advances after any stalled cycle.
    task automatic push(input string tag, input logic st, input logic [4:0] comb);
        exp_t e;
        e.tag = tag;
        e.v   = {st, comb, exp_err, exp_cnt};
        sb.push_back(e);
        if (comb[4] && (exp_cnt != {CNT_W{1'b1}}))
            exp_cnt = exp_cnt + CNT_W'(1);
    endtask

    task automatic check();
        exp_t             e;
        logic [EXP_W-1:0] obs;
        obs = {bus.mdu_start, bus.stall_ifr, bus.flush_ifr, bus.stall_idc,
               bus.flush_idc, bus.stall_ex, bus.mdu_err, bus.stall_cycles};
        e = sb.pop_front();
        total++;
        assert (obs === e.v) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
        end
    endtask

    task automatic cyc(input string tag, input in_t i, input logic st, input logic [4:0] comb);
        @(posedge clk);
        #1;
        apply(i);
        push(tag, st, comb);
        @(negedge clk);
        check();
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge can act.
    task automatic reset_now(input string tag);
        #2 reset = 1'b1;
        exp_cnt = '0;
        exp_err = 1'b0;
        #1;
        push(tag, 1'b0, C_NONE);
        check();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        z = '0;
        lu = z; lu.dm = 3'b010; lu.rd = 5'd5; lu.wr = 1'b1;
        lu.rs1 = 5'd5; lu.rs1_used = 1'b1; lu.rs2 = 5'd7; lu.rs2_used = 1'b1;
        lb = z; lb.rs1 = 5'd5; lb.rs1_used = 1'b1;
        m  = z; m.msel = 1'b1;
        d  = z; d.done = 1'b1;
        rz = z; rz.redir = 1'b1;

        reset = 1'b0;
        apply(z);
        @(negedge clk);
        reset_now("reset_init");

        // Load-use detection
        cyc("lu_hit", lu, 1'b0, C_LU);
        cyc("lu_clear", lb, 1'b0, C_NONE);
        t = lu; t.rd = 5'd0; t.rs1 = 5'd0;
        cyc("lu_rd0", t, 1'b0, C_NONE);
        t = lu; t.rs1 = 5'd9; t.rs2 = 5'd5;
        cyc("lu_rs2", t, 1'b0, C_LU);
        t.rs2_used = 1'b0;
        cyc("lu_rs2_unused", t, 1'b0, C_NONE);
        t = lu; t.dm = 3'd0;
        cyc("lu_noload", t, 1'b0, C_NONE);
        t = lu; t.wr = 1'b0;
        cyc("lu_nowr", t, 1'b0, C_NONE);

        // MDU with done four cycles after start
        reset_now("reset_pre_mdu");
        cyc("mdu_issue", m, 1'b0, C_MDU);
        cyc("mdu_start", z, 1'b1, C_MDU);
        for (int k = 0; k < 3; k++) cyc("mdu_wait", z, 1'b0, C_MDU);
        cyc("mdu_done", d, 1'b0, C_MDU);
        cyc("mdu_release", z, 1'b0, C_NONE);
        cyc("idle_done", d, 1'b0, C_NONE);
        cyc("idle_after_done", z, 1'b0, C_NONE);

        // Redirect beats load-use and m_sel
        t = lu; t.redir = 1'b1;
        cyc("redir_lu", t, 1'b0, C_FLUSH);
        cyc("redir_nobubble", z, 1'b0, C_NONE);
        t = m; t.redir = 1'b1;
        cyc("redir_msel", t, 1'b0, C_FLUSH);
        cyc("redir_msel_after", z, 1'b0, C_NONE);

        // Timeout; done in MDU_START and redirect in MDU_WAIT are ignored
        cyc("tmo_issue", m, 1'b0, C_MDU);
        cyc("tmo_start_done", d, 1'b1, C_MDU);
        for (int k = 0; k < 8; k++) cyc("tmo_wait", (k == 2) ? rz : z, 1'b0, C_MDU);
        exp_err = 1'b1;
        cyc("tmo_err", z, 1'b0, C_NONE);
        cyc("tmo_err_sticky", z, 1'b0, C_NONE);

        // Reset while waiting on the MDU
        cyc("rw_issue", m, 1'b0, C_MDU);
        cyc("rw_start", z, 1'b1, C_MDU);
        cyc("rw_wait", z, 1'b0, C_MDU);
        cyc("rw_wait", z, 1'b0, C_MDU);
        reset_now("reset_in_wait");
        cyc("late_done", d, 1'b0, C_NONE);
        cyc("late_done_after", z, 1'b0, C_NONE);

        // Counter saturation under back-to-back MDU stalls
        for (int k = 0; k < 20; k++) begin
            if (k == 10) exp_err = 1'b1;
            cyc("sat_hold", m, (k % 10 == 1), C_MDU);
        end
        cyc("sat_final", z, 1'b0, C_NONE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
